// File: rtl/bus_master_seq.sv
// Queued bus master: pops one request per transaction, drives addr/cmd/wr channels independently, masks-compares read data.
// Head pops the edge after a push into an empty queue; req_ready drops while the queue is full, bus readies stall issue.
module bus_master_seq #(
  parameter int W     = 8,
  parameter int A     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [A-1:0]  req_addr,
  input  logic [W-1:0]  req_data,
  input  logic [W-1:0]  req_mask,
  output logic [A-1:0]  addr,
  output logic          addr_val,
  input  logic          addr_rdy,
  output logic          cmd,
  output logic          cmd_val,
  input  logic          cmd_rdy,
  output logic [W-1:0]  wr_data,
  output logic          wr_val,
  input  logic          wr_rdy,
  input  logic [W-1:0]  rd_data,
  input  logic          rd_val,
  output logic          rd_rdy,
  input  logic          clr_cnt,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          err_pulse,
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic         op;
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic [W-1:0] mask;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA} state_t;

  req_t          fifo_q [DEPTH];
  req_t          req_in, head;
  logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          fifo_empty, fifo_full, push, pop;

  state_t        state_q, state_d;
  logic          addr_val_q, addr_val_d, cmd_val_q, cmd_val_d, wr_val_q, wr_val_d;
  logic          op_q, op_d;
  logic [A-1:0]  addr_q, addr_d;
  logic [W-1:0]  data_q, data_d, mask_q, mask_d;
  logic [CW-1:0] pass_q, pass_d, fail_q, fail_d;
  logic          err_q, err_d;
  logic          addr_done, cmd_done, wr_done, rd_match;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign req_in     = '{op: req_op, addr: req_addr, data: req_data, mask: req_mask};
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push       = req_valid && !fifo_full;
  assign head       = fifo_q[rptr_q[PW-1:0]];
  assign wptr_d     = push ? wptr_q + (PW+1)'(1) : wptr_q;
  assign rptr_d     = pop  ? rptr_q + (PW+1)'(1) : rptr_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PW-1:0]] <= req_in;
  end

  // A channel counts as done if it is already idle or transfers at this edge.
  assign addr_done = !addr_val_q || addr_rdy;
  assign cmd_done  = !cmd_val_q  || cmd_rdy;
  assign wr_done   = !wr_val_q   || wr_rdy;
  assign rd_match  = ((rd_data ^ data_q) & mask_q) == '0;
  assign rd_rdy    = (state_q == S_RDATA);

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    addr_val_d = addr_val_q && !addr_rdy;
    cmd_val_d  = cmd_val_q && !cmd_rdy;
    wr_val_d   = wr_val_q && !wr_rdy;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          addr_val_d = 1'b1;
          cmd_val_d  = 1'b1;
          wr_val_d   = head.op;
          op_d       = head.op;
          addr_d     = head.addr;
          data_d     = head.data;
          mask_d     = head.mask;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (addr_done && cmd_done && wr_done) state_d = op_q ? S_IDLE : S_RDATA;
      end
      S_RDATA: begin
        if (rd_val) begin
          state_d = S_IDLE;
          if (rd_match) begin
            if (pass_q != '1) pass_d = pass_q + CW'(1);
          end else begin
            err_d = 1'b1;
            if (fail_q != '1) fail_d = fail_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_cnt) begin
      pass_d = '0;
      fail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      addr_val_q <= 1'b0;
      cmd_val_q  <= 1'b0;
      wr_val_q   <= 1'b0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      addr_val_q <= addr_val_d;
      cmd_val_q  <= cmd_val_d;
      wr_val_q   <= wr_val_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
    end
  end

  // Payloads read as zero whenever their valid is low.
  assign addr      = addr_val_q ? addr_q : '0;
  assign cmd       = cmd_val_q && op_q;
  assign wr_data   = wr_val_q ? data_q : '0;
  assign addr_val  = addr_val_q;
  assign cmd_val   = cmd_val_q;
  assign wr_val    = wr_val_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign err_pulse = err_q;
  assign req_ready = !fifo_full;
  assign idle      = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench for bus_master_seq: read-compare vector table plus hand sequences for write, stagger, full queue and reset.
module tb_bus_master_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_op;
  logic [7:0] req_addr, req_data, req_mask;
  logic [7:0] addr;
  logic       addr_val, addr_rdy;
  logic       cmd, cmd_val, cmd_rdy;
  logic [7:0] wr_data;
  logic       wr_val, wr_rdy;
  logic [7:0] rd_data;
  logic       rd_val, rd_rdy;
  logic       clr_cnt;
  logic [3:0] pass_cnt, fail_cnt;
  logic       err_pulse, idle;

  bus_master_seq #(.W(8), .A(8), .DEPTH(4), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .addr(addr), .addr_val(addr_val), .addr_rdy(addr_rdy),
    .cmd(cmd), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .wr_data(wr_data), .wr_val(wr_val), .wr_rdy(wr_rdy),
    .rd_data(rd_data), .rd_val(rd_val), .rd_rdy(rd_rdy),
    .clr_cnt(clr_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_pulse(err_pulse), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] e;
    logic [7:0] m;
    logic [7:0] d;
    int         dly;
    logic       match;
    logic       clr;
  } vec_t;

  vec_t vt [9];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_pass = 0;
  int   exp_fail = 0;

  logic [7:0] aq[$];
  logic [7:0] wq[$];
  logic       cq[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (addr_val && addr_rdy) aq.push_back(addr);
      if (wr_val && wr_rdy) wq.push_back(wr_data);
      if (cmd_val && cmd_rdy) cq.push_back(cmd);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      step();
      n++;
    end
    chk(nm, idle, 1);
  endtask

  task automatic run_read(input vec_t v, input string nm);
    req_op = 1'b0; req_addr = v.a; req_data = v.e; req_mask = v.m; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk({nm, ".addr_val"}, addr_val, 1);
    chk({nm, ".addr"}, addr, v.a);
    chk({nm, ".cmd_val"}, cmd_val, 1);
    chk({nm, ".cmd"}, cmd, 0);
    chk({nm, ".wr_val"}, wr_val, 0);
    chk({nm, ".rd_rdy_issue"}, rd_rdy, 0);
    // Stray read data while still issuing must be ignored.
    rd_val = 1'b1; rd_data = ~v.d;
    step();
    rd_val = 1'b0;
    chk({nm, ".rd_rdy_rdata"}, rd_rdy, 1);
    chk({nm, ".addr_val_drop"}, addr_val, 0);
    chk({nm, ".pass_hold"}, pass_cnt, exp_pass);
    chk({nm, ".fail_hold"}, fail_cnt, exp_fail);
    for (int i = 0; i < v.dly; i++) begin
      step();
      chk({nm, ".rd_rdy_wait"}, rd_rdy, 1);
    end
    rd_val = 1'b1; rd_data = v.d; clr_cnt = v.clr;
    step();
    rd_val = 1'b0; clr_cnt = 1'b0;
    if (v.clr) begin
      exp_pass = 0;
      exp_fail = 0;
    end else if (v.match) begin
      if (exp_pass < 15) exp_pass++;
    end else begin
      if (exp_fail < 15) exp_fail++;
    end
    chk({nm, ".rd_rdy_done"}, rd_rdy, 0);
    chk({nm, ".err_pulse"}, err_pulse, !v.match);
    chk({nm, ".pass_cnt"}, pass_cnt, exp_pass);
    chk({nm, ".fail_cnt"}, fail_cnt, exp_fail);
    step();
    chk({nm, ".err_pulse_end"}, err_pulse, 0);
    chk({nm, ".idle"}, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h05, 8'hA5, 8'hFF, 8'hA5, 3, 1'b1, 1'b0};
    vt[1] = '{8'h06, 8'hA5, 8'h0F, 8'h55, 0, 1'b1, 1'b0};
    vt[2] = '{8'h07, 8'hA5, 8'h0F, 8'hA4, 0, 1'b0, 1'b0};
    vt[3] = '{8'h08, 8'h3C, 8'hF0, 8'h3F, 1, 1'b1, 1'b0};
    vt[4] = '{8'h09, 8'h3C, 8'hF0, 8'h2C, 0, 1'b0, 1'b0};
    vt[5] = '{8'h0A, 8'hFF, 8'h00, 8'h00, 2, 1'b1, 1'b0};
    vt[6] = '{8'h0B, 8'h80, 8'h80, 8'h7F, 0, 1'b0, 1'b0};
    vt[7] = '{8'h0C, 8'h11, 8'hFF, 8'h12, 0, 1'b0, 1'b1};
    vt[8] = '{8'h0D, 8'h11, 8'hFF, 8'h11, 0, 1'b1, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
    addr_rdy = 1'b1; cmd_rdy = 1'b1; wr_rdy = 1'b1; rd_data = '0; rd_val = 1'b0; clr_cnt = 1'b0;
    step();
    chk("rst.req_ready", req_ready, 1);
    chk("rst.idle", idle, 1);
    chk("rst.vals", {addr_val, cmd_val, wr_val, rd_rdy, err_pulse}, 0);
    chk("rst.payload", {addr, cmd, wr_data}, 0);
    chk("rst.cnts", {pass_cnt, fail_cnt}, 0);
    rst_n = 1'b1;
    step();

    // Single write, all readies high: one cycle of valid, then idle.
    req_op = 1'b1; req_addr = 8'h12; req_data = 8'h34; req_mask = 8'h00; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("t1.no_val_before_pop", addr_val, 0);
    chk("t1.idle_busy", idle, 0);
    step();
    chk("t1.vals", {addr_val, cmd_val, wr_val}, 3'b111);
    chk("t1.addr", addr, 8'h12);
    chk("t1.cmd", cmd, 1);
    chk("t1.wr_data", wr_data, 8'h34);
    step();
    chk("t1.vals_drop", {addr_val, cmd_val, wr_val}, 3'b000);
    chk("t1.payload_zero", {addr, cmd, wr_data}, 0);
    chk("t1.idle", idle, 1);

    // Staggered readies; a queued read must wait for the write to finish.
    addr_rdy = 1'b0; cmd_rdy = 1'b0; wr_rdy = 1'b0;
    aq.delete(); wq.delete(); cq.delete();
    req_op = 1'b1; req_addr = 8'h21; req_data = 8'h43; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("t2.c1_vals", {addr_val, cmd_val, wr_val}, 3'b111);
    req_op = 1'b0; req_addr = 8'h30; req_data = 8'h00; req_mask = 8'h00; req_valid = 1'b1;
    addr_rdy = 1'b1;
    step();
    req_valid = 1'b0; addr_rdy = 1'b0;
    chk("t2.c2_vals", {addr_val, cmd_val, wr_val}, 3'b011);
    chk("t2.c2_addr_zero", addr, 0);
    step();
    chk("t2.c3_vals", {addr_val, cmd_val, wr_val}, 3'b011);
    wr_rdy = 1'b1;
    step();
    wr_rdy = 1'b0;
    chk("t2.c4_vals", {addr_val, cmd_val, wr_val}, 3'b010);
    chk("t2.c4_wr_zero", wr_data, 0);
    step();
    chk("t2.c5_vals", {addr_val, cmd_val, wr_val}, 3'b010);
    cmd_rdy = 1'b1;
    step();
    addr_rdy = 1'b1; wr_rdy = 1'b1;
    chk("t2.c6_vals", {addr_val, cmd_val, wr_val}, 3'b000);
    step();
    chk("t2.rd_vals", {addr_val, cmd_val, wr_val}, 3'b110);
    chk("t2.rd_addr", addr, 8'h30);
    chk("t2.rd_cmd", cmd, 0);
    step();
    chk("t2.rd_rdy", rd_rdy, 1);
    rd_val = 1'b1; rd_data = 8'h99;
    step();
    rd_val = 1'b0;
    exp_pass = 1;
    chk("t2.pass_cnt", pass_cnt, exp_pass);
    chk("t2.addr_xfers", aq.size(), 2);
    chk("t2.wr_xfers", wq.size(), 1);
    chk("t2.cmd_xfers", cq.size(), 2);
    step();

    for (int i = 0; i < 9; i++) run_read(vt[i], $sformatf("vec%0d", i));

    // Drive the pass counter into saturation.
    for (int i = 0; i < 16; i++) run_read('{8'hE0, 8'h00, 8'h00, 8'h5A, 0, 1'b1, 1'b0}, $sformatf("sat%0d", i));
    chk("sat.pass_max", pass_cnt, 15);

    // Fill the queue with the bus stalled, then drain in order.
    addr_rdy = 1'b0; cmd_rdy = 1'b0; wr_rdy = 1'b0;
    aq.delete(); wq.delete(); cq.delete();
    for (int i = 0; i < 6; i++) begin
      req_op = 1'b1; req_addr = 8'(8'h40 + i); req_data = 8'(8'h50 + i); req_valid = 1'b1;
      chk($sformatf("t5.ready%0d", i), req_ready, (i < 5));
      if (i < 5) step();
    end
    step();
    step();
    chk("t5.still_full", req_ready, 0);
    chk("t5.head_addr", addr, 8'h40);
    chk("t5.no_xfers", aq.size(), 0);
    addr_rdy = 1'b1; cmd_rdy = 1'b1; wr_rdy = 1'b1;
    begin
      int n = 0;
      while (!req_ready && n < 20) begin
        step();
        n++;
      end
    end
    chk("t5.ready_timeout", req_ready, 1);
    step();
    req_valid = 1'b0;
    wait_idle("t5.drain_timeout", 60);
    chk("t5.addr_count", aq.size(), 6);
    chk("t5.wr_count", wq.size(), 6);
    if (aq.size() == 6 && wq.size() == 6 && cq.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t5.addr%0d", i), aq[i], 8'h40 + i);
        chk($sformatf("t5.wdat%0d", i), wq[i], 8'h50 + i);
        chk($sformatf("t5.cmd%0d", i), cq[i], 1);
      end
    end

    // Reset while a write is being issued and a read is queued.
    addr_rdy = 1'b0; cmd_rdy = 1'b0; wr_rdy = 1'b0;
    req_op = 1'b1; req_addr = 8'h66; req_data = 8'h77; req_valid = 1'b1;
    step();
    req_op = 1'b0; req_addr = 8'h67; req_data = 8'h00;
    step();
    req_valid = 1'b0;
    chk("t6.issuing", {addr_val, cmd_val, wr_val}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("t6.vals", {addr_val, cmd_val, wr_val, rd_rdy, err_pulse}, 0);
    chk("t6.cnts", {pass_cnt, fail_cnt}, 0);
    chk("t6.ready", req_ready, 1);
    chk("t6.idle", idle, 1);
    step();
    addr_rdy = 1'b1; cmd_rdy = 1'b1; wr_rdy = 1'b1;
    aq.delete(); wq.delete(); cq.delete();
    rst_n = 1'b1;
    repeat (4) step();
    chk("t6.no_stray", aq.size() + wq.size() + cq.size(), 0);
    chk("t6.idle_after", idle, 1);
    chk("t6.addr_val_after", addr_val, 0);
    exp_pass = 0;
    exp_fail = 0;
    run_read('{8'h70, 8'hC3, 8'hFF, 8'hC2, 0, 1'b0, 1'b0}, "t6.recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
